// File: rtl/anabellek_hakemi_pkg.sv
// Shared constants and the latched transaction bundle for the main-memory arbiter.
package anabellek_paket;

    localparam int OBEK_BIT  = 128;
    localparam int ADRES_BIT = 32;

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] ISTEK = 2'd1;
    localparam logic [1:0] BEKLE = 2'd2;
    localparam logic [1:0] TAMAM = 2'd3;

    localparam logic SAHIP_GETIR = 1'b0;
    localparam logic SAHIP_VERI  = 1'b1;

    localparam logic [ADRES_BIT-1:0] ADRES_MASKE =
        {{(ADRES_BIT-4){1'b1}}, 4'h0};

    typedef struct packed {
        logic                 sahip;
        logic                 oku;
        logic                 yaz;
        logic [ADRES_BIT-1:0] adres;
        logic [OBEK_BIT-1:0]  obek;
    } islem_t;

    function automatic logic [ADRES_BIT-1:0] blok_hizala(
        input logic [ADRES_BIT-1:0] a
    );
        return a & ADRES_MASKE;
    endfunction

endpackage

// File: rtl/anabellek_hakemi_secici.sv
// Fetch/data arbitration: data wins unless fetch has waited ACLIK_SINIRI grants.
module anabellek_secici
    import anabellek_paket::*;
#(
    parameter int ACLIK_SINIRI = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bosta,
    input  logic getir_istek,
    input  logic veri_istek,
    output logic kazanan,
    output logic verildi
);

    localparam logic [3:0] SINIR = 4'(ACLIK_SINIRI);

    logic [3:0] aclik_q;

    always_comb begin
        verildi = bosta && (getir_istek || veri_istek);
        kazanan = SAHIP_VERI;
        if (getir_istek && (!veri_istek || aclik_q == SINIR))
            kazanan = SAHIP_GETIR;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            aclik_q <= '0;
        end else if (!getir_istek) begin
            aclik_q <= '0;
        end else if (verildi) begin
            if (kazanan == SAHIP_GETIR)
                aclik_q <= '0;
            else
                aclik_q <= aclik_q + 4'd1;
        end
    end

endmodule

// File: rtl/anabellek_hakemi.sv
// Single-port main-memory arbiter/sequencer for getir and data cache.
// Optional BEKLE timeout with sticky hata_o: ANABELLEK_ZAMAN_ASIMI_EN.
module anabellek_hakemi
    import anabellek_paket::*;
#(
    parameter int ACLIK_SINIRI = 4,
    parameter int ZAMAN_ASIMI  = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 getir_istek_i,
    input  logic [ADRES_BIT-1:0] getir_adres_i,
    output logic                 getir_musait_o,
    output logic                 getir_veri_hazir_o,
    output logic [OBEK_BIT-1:0]  getir_obek_o,
    input  logic                 veri_istek_i,
    input  logic [ADRES_BIT-1:0] veri_adres_i,
    input  logic                 veri_oku_i,
    input  logic                 veri_yaz_i,
    input  logic [OBEK_BIT-1:0]  veri_yaz_obek_i,
    output logic                 veri_musait_o,
    output logic                 veri_hazir_o,
    output logic [OBEK_BIT-1:0]  veri_obek_o,
    output logic                 bellek_istek_o,
    output logic [ADRES_BIT-1:0] bellek_adres_o,
    output logic                 bellek_oku_o,
    output logic                 bellek_yaz_o,
    output logic [OBEK_BIT-1:0]  bellek_yaz_obek_o,
    input  logic                 bellek_musait_i,
    input  logic                 bellek_hazir_i,
    input  logic [OBEK_BIT-1:0]  bellek_obek_i,
    output logic                 hata_o
);

    if (ACLIK_SINIRI < 1 || ACLIK_SINIRI > 15 || ZAMAN_ASIMI < 1)
    begin : g_param_hata
        $error("anabellek_hakemi: parameter out of range");
    end

    logic [1:0]          durum_q;
    logic [1:0]          durum_d;
    islem_t              islem_q;
    islem_t              secim;
    logic                kazanan;
    logic                verildi;
    logic                zaman_doldu;
    logic                bitis;
    logic [OBEK_BIT-1:0] yanit_obek;
    logic [OBEK_BIT-1:0] getir_obek_q;
    logic [OBEK_BIT-1:0] veri_obek_q;

    anabellek_secici #(
        .ACLIK_SINIRI(ACLIK_SINIRI)
    ) u_secici (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bosta      (durum_q == BOSTA),
        .getir_istek(getir_istek_i),
        .veri_istek (veri_istek_i),
        .kazanan    (kazanan),
        .verildi    (verildi)
    );

    // Neither oku nor yaz asserted still means a read refill.
    always_comb begin
        secim = '0;
        if (kazanan == SAHIP_GETIR) begin
            secim.sahip = SAHIP_GETIR;
            secim.oku   = 1'b1;
            secim.adres = blok_hizala(getir_adres_i);
        end else begin
            secim.sahip = SAHIP_VERI;
            secim.adres = blok_hizala(veri_adres_i);
            priority case (1'b1)
                veri_yaz_i: begin
                    secim.yaz  = 1'b1;
                    secim.obek = veri_yaz_obek_i;
                end
                veri_oku_i: secim.oku = 1'b1;
                default:    secim.oku = 1'b1;
            endcase
        end
    end

`ifdef ANABELLEK_ZAMAN_ASIMI_EN
    localparam int SW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [SW-1:0] SON = SW'(ZAMAN_ASIMI - 1);

    logic [SW-1:0] sayac_q;
    logic          hata_q;

    assign zaman_doldu = (durum_q == BEKLE) && !bellek_hazir_i &&
                         (sayac_q == SON);
    assign hata_o = hata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sayac_q <= '0;
            hata_q  <= 1'b0;
        end else begin
            sayac_q <= (durum_q == BEKLE) ? sayac_q + SW'(1) : '0;
            if (zaman_doldu)
                hata_q <= 1'b1;
        end
    end
`else
    assign zaman_doldu = 1'b0;
    assign hata_o      = 1'b0;
`endif

    assign bitis = ((durum_q == BEKLE) && bellek_hazir_i) || zaman_doldu;
    assign yanit_obek = bellek_hazir_i ? bellek_obek_i : '0;

    always_comb begin
        durum_d = durum_q;
        unique case (durum_q)
            BOSTA: if (verildi)         durum_d = ISTEK;
            ISTEK: if (bellek_musait_i) durum_d = BEKLE;
            BEKLE: if (bitis)           durum_d = TAMAM;
            TAMAM:                      durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            durum_q      <= BOSTA;
            islem_q      <= '0;
            getir_obek_q <= '0;
            veri_obek_q  <= '0;
        end else begin
            durum_q <= durum_d;
            if (verildi)
                islem_q <= secim;
            if (bitis && islem_q.oku) begin
                if (islem_q.sahip == SAHIP_GETIR)
                    getir_obek_q <= yanit_obek;
                else
                    veri_obek_q <= yanit_obek;
            end
        end
    end

    assign getir_musait_o     = (durum_q == BOSTA);
    assign veri_musait_o      = (durum_q == BOSTA);
    assign getir_veri_hazir_o = (durum_q == TAMAM) &&
                                (islem_q.sahip == SAHIP_GETIR);
    assign veri_hazir_o       = (durum_q == TAMAM) &&
                                (islem_q.sahip == SAHIP_VERI);
    assign getir_obek_o       = getir_obek_q;
    assign veri_obek_o        = veri_obek_q;
    assign bellek_istek_o     = (durum_q == ISTEK);
    assign bellek_adres_o     = islem_q.adres;
    assign bellek_oku_o       = islem_q.oku;
    assign bellek_yaz_o       = islem_q.yaz;
    assign bellek_yaz_obek_o  = islem_q.obek;

endmodule
